alu_issue: RTL

ID/EX issue stage for the pipelined CPU's ALU. It decodes the ID-stage instruction into an ALU selection code and builds the ALU `a`/`b` operands, with forwarding, immediate extension and shift-amount placement. The results are registered into the EX stage, with stall and flush control. Its outputs drive the ALU's `a`, `b` and `s` inputs directly, so it is the producing end of the ALU operand/selection interface.

---
 rtl/alu_issue.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue stage feeding the ALU a/b/s inputs.
// Decodes the ID instruction into an ALU selection code, builds the operands
// (forwarding, immediate extension, shift-amount placement) and registers the
// result into EX with flush-over-stall priority.

`ifndef ALU_SELECTION_WIDTH
`define ALU_SELECTION_WIDTH 4
`endif
`ifndef ADD_OP
`define ADD_OP 1
`endif
`ifndef SUB_OP
`define SUB_OP 2
`endif
`ifndef AND_OP
`define AND_OP 3
`endif
`ifndef OR_OP
`define OR_OP 4
`endif
`ifndef XOR_OP
`define XOR_OP 5
`endif
`ifndef SL_OP
`define SL_OP 6
`endif
`ifndef SRL_OP
`define SRL_OP 7
`endif
`ifndef SRA_OP
`define SRA_OP 8
`endif
`ifndef NOR_OP
`define NOR_OP 9
`endif
`ifndef LT_OP
`define LT_OP 10
`endif
`ifndef LTU_OP
`define LTU_OP 11
`endif

module alu_issue #(
  parameter int SEL_W = `ALU_SELECTION_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_rs_val,
  input  logic [31:0]      id_rt_val,
  input  logic [1:0]       fwd_rs_sel,
  input  logic [1:0]       fwd_rt_sel,
  input  logic [31:0]      mem_result,
  input  logic [31:0]      wb_result,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [SEL_W-1:0] ex_sel,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic [4:0]       ex_wreg,
  output logic             ex_illegal
);

  localparam logic [SEL_W-1:0] SEL_ADD = SEL_W'(`ADD_OP);
  localparam logic [SEL_W-1:0] SEL_SUB = SEL_W'(`SUB_OP);
  localparam logic [SEL_W-1:0] SEL_AND = SEL_W'(`AND_OP);
  localparam logic [SEL_W-1:0] SEL_OR  = SEL_W'(`OR_OP);
  localparam logic [SEL_W-1:0] SEL_XOR = SEL_W'(`XOR_OP);
  localparam logic [SEL_W-1:0] SEL_SL  = SEL_W'(`SL_OP);
  localparam logic [SEL_W-1:0] SEL_SRL = SEL_W'(`SRL_OP);
  localparam logic [SEL_W-1:0] SEL_SRA = SEL_W'(`SRA_OP);
  localparam logic [SEL_W-1:0] SEL_NOR = SEL_W'(`NOR_OP);
  localparam logic [SEL_W-1:0] SEL_LT  = SEL_W'(`LT_OP);
  localparam logic [SEL_W-1:0] SEL_LTU = SEL_W'(`LTU_OP);

  // instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  sh;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_se;
  logic [31:0] imm_ze;

  assign op     = id_instr[31:26];
  assign funct  = id_instr[5:0];
  assign sh     = id_instr[10:6];
  assign rt_idx = id_instr[20:16];
  assign rd_idx = id_instr[15:11];
  assign imm_se = {{16{id_instr[15]}}, id_instr[15:0]};
  assign imm_ze = {16'h0000, id_instr[15:0]};

  // The rs field is never needed here: its value arrives already read on id_rs_val.
  logic unused_rs_field;
  assign unused_rs_field = ^id_instr[25:21];

  // forwarded operand values
  logic [31:0] rs;
  logic [31:0] rt;

  // Forwarding muxes: select 0 and 3 both fall back to the register file.
  always_comb begin
    case (fwd_rs_sel)
      2'd1:    rs = mem_result;
      2'd2:    rs = wb_result;
      default: rs = id_rs_val;
    endcase
    case (fwd_rt_sel)
      2'd1:    rt = mem_result;
      2'd2:    rt = wb_result;
      default: rt = id_rt_val;
    endcase
  end

  // decoded next-EX values
  logic             d_legal;
  logic [SEL_W-1:0] d_sel;
  logic [31:0]      d_a;
  logic [31:0]      d_b;
  logic [4:0]       d_wreg;

  // Decode: R-type writes rd with b = rt; I-type writes rt with an immediate b.
  always_comb begin
    d_legal = 1'b1;
    d_sel   = SEL_ADD;
    d_a     = rs;
    d_b     = rt;
    d_wreg  = rd_idx;
    if (op == 6'h00) begin
      case (funct)
        6'h20, 6'h21: d_sel = SEL_ADD;
        6'h22, 6'h23: d_sel = SEL_SUB;
        6'h24:        d_sel = SEL_AND;
        6'h25:        d_sel = SEL_OR;
        6'h26:        d_sel = SEL_XOR;
        6'h27:        d_sel = SEL_NOR;
        6'h2A:        d_sel = SEL_LT;
        6'h2B:        d_sel = SEL_LTU;
        6'h00: begin
          d_sel = SEL_SL;
          d_a   = {27'b0, sh};
        end
        6'h02: begin
          d_sel = SEL_SRL;
          d_a   = {27'b0, sh};
        end
        6'h03: begin
          d_sel = SEL_SRA;
          d_a   = {27'b0, sh};
        end
        6'h04: begin
          d_sel = SEL_SL;
          d_a   = {27'b0, rs[4:0]};
        end
        6'h06: begin
          d_sel = SEL_SRL;
          d_a   = {27'b0, rs[4:0]};
        end
        6'h07: begin
          d_sel = SEL_SRA;
          d_a   = {27'b0, rs[4:0]};
        end
        default: d_legal = 1'b0;
      endcase
    end else begin
      d_wreg = rt_idx;
      case (op)
        6'h08, 6'h09: begin
          d_sel = SEL_ADD;
          d_b   = imm_se;
        end
        6'h0A: begin
          d_sel = SEL_LT;
          d_b   = imm_se;
        end
        6'h0B: begin
          d_sel = SEL_LTU;
          d_b   = imm_se;
        end
        6'h0C: begin
          d_sel = SEL_AND;
          d_b   = imm_ze;
        end
        6'h0D: begin
          d_sel = SEL_OR;
          d_b   = imm_ze;
        end
        6'h0E: begin
          d_sel = SEL_XOR;
          d_b   = imm_ze;
        end
        6'h0F: begin
          // lui: shift the zero-extended immediate left by 16
          d_sel = SEL_SL;
          d_a   = 32'd16;
          d_b   = imm_ze;
        end
        6'h23: begin
          d_sel = SEL_ADD;
          d_b   = imm_se;
        end
        6'h2B: begin
          d_sel  = SEL_ADD;
          d_b    = imm_se;
          d_wreg = 5'd0;
        end
        6'h04, 6'h05: begin
          // branch compare: a - b, nothing written back
          d_sel  = SEL_SUB;
          d_wreg = 5'd0;
        end
        default: d_legal = 1'b0;
      endcase
    end
    if (!d_legal) begin
      d_sel  = SEL_ADD;
      d_a    = 32'd0;
      d_b    = 32'd0;
      d_wreg = 5'd0;
    end
  end

  // EX register: reset, then flush (bubble), then stall (hold), then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_sel     <= '0;
      ex_a       <= 32'd0;
      ex_b       <= 32'd0;
      ex_wreg    <= 5'd0;
      ex_illegal <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid   <= 1'b0;
      ex_sel     <= SEL_ADD;
      ex_a       <= 32'd0;
      ex_b       <= 32'd0;
      ex_wreg    <= 5'd0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= 1'b1;
      ex_sel     <= d_sel;
      ex_a       <= d_a;
      ex_b       <= d_b;
      ex_wreg    <= d_wreg;
      ex_illegal <= !d_legal;
    end
  end

  // An illegal marker never appears in an empty EX slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!ex_illegal || ex_valid);
    end
  end

endmodule
